// File: rtl/sha3_seq.sv
// Block sequencer for a SHA3-256 core: packs 64-bit words into 1088-bit blocks,
// applies SHA3 padding and returns the digest. Define SHA3_SEQ_PERF_EN for blk_count.
module sha3_seq #(
  parameter logic [9:0] CTRL_FIRST = 10'b0000010011,
  parameter logic [9:0] CTRL_NEXT  = 10'b0000000011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  input  logic [2:0]    in_bytes,
  output logic          core_start,
  output logic [9:0]    core_ctrl,
  output logic [1151:0] core_in,
  input  logic          core_done,
  input  logic [511:0]  core_out,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic [255:0]  dig_data
`ifdef SHA3_SEQ_PERF_EN
  ,
  output logic [15:0]   blk_count
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    PAD   = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t          state_q;
  logic [4:0]      wcnt_q;
  logic [7:0]      end_q;
  logic            first_q;
  logic            last_q;
  logic            pend_q;
  logic            wait_first_q;
  logic            in_ready_q;
  logic            core_start_q;
  logic [9:0]      core_ctrl_q;
  logic [1151:0]   core_in_q;
  logic            dig_valid_q;
  logic [255:0]    dig_data_q;
`ifdef SHA3_SEQ_PERF_EN
  logic [15:0]     blk_count_q;
`endif

  logic            in_fire;
  logic [3:0]      in_nbytes;
  logic [7:0]      in_endpos;
  logic            core_out_unused;

  assign in_fire         = in_valid & in_ready_q;
  assign in_nbytes       = (in_bytes == 3'd0) ? 4'd8 : {1'b0, in_bytes};
  assign in_endpos       = {wcnt_q, 3'd0} + {4'd0, in_nbytes};
  assign core_out_unused = ^core_out[255:0];

  // Byte endp gets 0x06, later bytes are cleared, byte 135 gets 0x80 OR-ed in.
  function automatic logic [1151:0] pad_block(input logic [1151:0] blk,
                                              input logic [7:0] endp,
                                              input logic en);
    logic [1151:0] r;
    logic [7:0]    bi;
    r = blk;
    if (en) begin
      for (int b = 0; b < 136; b++) begin
        bi = 8'(b);
        if (bi == endp) begin
          r[11'd1151 - {bi, 3'd0} -: 8] = 8'h06;
        end else if (bi > endp) begin
          r[11'd1151 - {bi, 3'd0} -: 8] = 8'h00;
        end
      end
      r[71:64] = r[71:64] | 8'h80;
    end
    r[63:0] = 64'd0;
    return r;
  endfunction

  // Sequencer state machine with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wcnt_q       <= 5'd0;
      end_q        <= 8'd0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      pend_q       <= 1'b0;
      wait_first_q <= 1'b0;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      core_ctrl_q  <= CTRL_FIRST;
      core_in_q    <= '0;
      dig_valid_q  <= 1'b0;
      dig_data_q   <= 256'd0;
`ifdef SHA3_SEQ_PERF_EN
      blk_count_q  <= 16'd0;
`endif
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        IDLE, FILL: begin
          if (in_fire) begin
            core_in_q[11'd1151 - {wcnt_q, 6'd0} -: 64] <= in_data;
            if (state_q == IDLE) begin
              first_q <= 1'b1;
            end
            if (in_last || (wcnt_q == 5'd16)) begin
              // A message filling the block exactly leaves an all-pad block pending.
              last_q     <= in_last;
              end_q      <= in_endpos;
              pend_q     <= in_last && (in_endpos == 8'd136);
              in_ready_q <= 1'b0;
              state_q    <= PAD;
            end else begin
              wcnt_q     <= wcnt_q + 5'd1;
              in_ready_q <= 1'b1;
              state_q    <= FILL;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        PAD: begin
          core_in_q    <= pad_block(core_in_q, end_q, last_q & ~pend_q);
          core_start_q <= 1'b1;
          core_ctrl_q  <= first_q ? CTRL_FIRST : CTRL_NEXT;
`ifdef SHA3_SEQ_PERF_EN
          if (blk_count_q != 16'hFFFF) begin
            blk_count_q <= blk_count_q + 16'd1;
          end
`endif
          state_q      <= START;
        end
        START: begin
          wait_first_q <= 1'b1;
          state_q      <= WAIT;
        end
        WAIT: begin
          // core_done in the first WAIT cycle may be left over from the previous block.
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (core_done) begin
            first_q <= 1'b0;
            if (pend_q) begin
              pend_q  <= 1'b0;
              end_q   <= 8'd0;
              state_q <= PAD;
            end else if (last_q) begin
              dig_data_q  <= core_out[511:256];
              dig_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              wcnt_q     <= 5'd0;
              in_ready_q <= 1'b1;
              state_q    <= FILL;
            end
          end
        end
        OUT: begin
          if (dig_ready) begin
            dig_valid_q <= 1'b0;
            wcnt_q      <= 5'd0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign core_start = core_start_q;
  assign core_ctrl  = core_ctrl_q;
  assign core_in    = core_in_q;
  assign dig_valid  = dig_valid_q;
  assign dig_data   = dig_data_q;
`ifdef SHA3_SEQ_PERF_EN
  assign blk_count  = blk_count_q;
`endif

endmodule

// File: tb/tb_sha3_seq.sv
// Self-checking bench for sha3_seq: vector table, corner sequences and random
// messages checked against a byte-level SHA3 padding model and a stand-in core.
module tb_sha3_seq;

  localparam logic [9:0] CTRL_FIRST = 10'b0000010011;
  localparam logic [9:0] CTRL_NEXT  = 10'b0000000011;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [1151:0] blk;
    logic [9:0]    ctrl;
  } exp_t;
  typedef struct {
    int         len;
    int         starts;
    logic [7:0] b0;
    logic [7:0] b135;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [2:0]    in_bytes;
  logic          core_start;
  logic [9:0]    core_ctrl;
  logic [1151:0] core_in;
  logic          core_done;
  logic [511:0]  core_out;
  logic          dig_valid;
  logic          dig_ready;
  logic [255:0]  dig_data;

  int            n_checks;
  int            n_err;
  int            n_starts;
  int            hold_at;
  bit            stale_mode;
  logic [511:0]  last_out;
  logic [1151:0] last_core_in;
  exp_t          exp_q[$];

  sha3_seq #(.CTRL_FIRST(CTRL_FIRST), .CTRL_NEXT(CTRL_NEXT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .core_start(core_start), .core_ctrl(core_ctrl), .core_in(core_in),
    .core_done(core_done), .core_out(core_out),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [1151:0] act, input logic [1151:0] exp);
    int fb;
    logic [7:0] ab, eb;
    n_checks++;
    if (act !== exp) begin
      n_err++;
      fb = 0;
      for (int b = 143; b >= 0; b--) begin
        if (act[1151 - 8*b -: 8] !== exp[1151 - 8*b -: 8]) fb = b;
      end
      ab = act[1151 - 8*fb -: 8];
      eb = exp[1151 - 8*fb -: 8];
      $display("FAIL %s: first bad byte %0d got %h expected %h", nm, fb, ab, eb);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference: SHA3 pad10*1 with domain byte 0x06, split into 136-byte blocks.
  function automatic void build_blocks(input bq_t m);
    bq_t  p;
    exp_t e;
    int   nb;
    p = m;
    p.push_back(8'h06);
    while (p.size() % 136 != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nb = p.size() / 136;
    for (int k = 0; k < nb; k++) begin
      e.blk = '0;
      for (int b = 0; b < 136; b++) e.blk[1151 - 8*b -: 8] = p[136*k + b];
      e.ctrl = (k == 0) ? CTRL_FIRST : CTRL_NEXT;
      exp_q.push_back(e);
    end
  endfunction

  // Stand-in core: checks each block on core_start, then raises done and holds it.
  initial begin : core_model
    int   d;
    exp_t e;
    core_done = 1'b0;
    core_out  = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        n_starts++;
        last_core_in = core_in;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_core_start", 256'(n_starts), 256'd0);
        end else begin
          e = exp_q.pop_front();
          chk_blk("core_in", core_in, e.blk);
          chk(core_ctrl === e.ctrl, "core_ctrl", 256'(core_ctrl), 256'(e.ctrl));
        end
        if (stale_mode) begin
          core_out  = rnd512();
          last_out  = core_out;
          core_done = 1'b1;
        end else begin
          core_done = 1'b0;
          if (n_starts != hold_at) begin
            d = int'($urandom_range(1, 5));
            @(negedge clk);
            chk(core_start === 1'b0, "start_one_cycle", 256'(core_start), 256'd0);
            repeat (d - 1) @(negedge clk);
            core_out  = rnd512();
            last_out  = core_out;
            core_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic last, input logic [2:0] nb);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    t = 0;
    while (in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk(1'b0, "in_ready_timeout", 256'(t), 256'd300);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = {$urandom, $urandom};
    in_bytes = 3'($urandom_range(0, 7));
  endtask

  // Sends a whole message; returns on the cycle core_start is expected for the final word.
  task automatic send_msg(input bq_t m, input int gap_max, input bit garbage);
    int L, nw;
    L  = m.size();
    nw = (L + 7) / 8;
    build_blocks(m);
    for (int w = 0; w < nw; w++) begin
      logic [63:0] d;
      bit          last;
      d = garbage ? {$urandom, $urandom} : 64'd0;
      for (int j = 0; j < 8; j++) begin
        if (8*w + j < L) d[63 - 8*j -: 8] = m[8*w + j];
      end
      last = (w == nw - 1);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_word(d, last, last ? 3'(L % 8) : 3'($urandom_range(0, 7)));
    end
    chk(core_start === 1'b0, "start_latency_pad", 256'(core_start), 256'd0);
    @(negedge clk);
    chk(core_start === 1'b1, "start_latency", 256'(core_start), 256'd1);
  endtask

  task automatic wait_dig();
    int t;
    t = 0;
    while (dig_valid !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(t < 2000, "dig_valid_timeout", 256'(t), 256'd2000);
  endtask

  task automatic finish_msg();
    wait_dig();
    chk(dig_data === last_out[511:256], "digest", dig_data, last_out[511:256]);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk(dig_valid === 1'b1, "dig_valid_held", 256'(dig_valid), 256'd1);
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
    chk(dig_valid === 1'b0, "dig_release", 256'(dig_valid), 256'd0);
    chk(exp_q.size() == 0, "blocks_pending", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk(in_ready === 1'b0, {tag, "_in_ready"}, 256'(in_ready), 256'd0);
    chk(core_start === 1'b0, {tag, "_core_start"}, 256'(core_start), 256'd0);
    chk(core_ctrl === CTRL_FIRST, {tag, "_core_ctrl"}, 256'(core_ctrl), 256'(CTRL_FIRST));
    chk(core_in === '0, {tag, "_core_in"}, 256'(|core_in), 256'd0);
    chk(dig_valid === 1'b0, {tag, "_dig_valid"}, 256'(dig_valid), 256'd0);
    chk(dig_data === 256'd0, {tag, "_dig_data"}, dig_data, 256'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t          tbl[7];
    bq_t           m;
    int            s0;
    logic [255:0]  exp_dig;

    n_checks = 0; n_err = 0; n_starts = 0; hold_at = -1; stale_mode = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_data = 64'd0; in_last = 1'b0;
    in_bytes = 3'd0; dig_ready = 1'b0; last_out = '0; last_core_in = '0;

    tbl[0] = '{3,   1, 8'h61, 8'h80};
    tbl[1] = '{1,   1, 8'h61, 8'h80};
    tbl[2] = '{8,   1, 8'h61, 8'h80};
    tbl[3] = '{135, 1, 8'h61, 8'h86};
    tbl[4] = '{136, 2, 8'h06, 8'h80};
    tbl[5] = '{137, 2, 8'hE9, 8'h80};
    tbl[6] = '{272, 3, 8'h06, 8'h80};

    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    @(negedge clk);
    chk(in_ready === 1'b1, "in_ready_after_rst", 256'(in_ready), 256'd1);

    // Table: message bytes 0x61, 0x62, ... so length 3 is "abc".
    for (int v = 0; v < 7; v++) begin
      m = {};
      for (int i = 0; i < tbl[v].len; i++) m.push_back(8'(8'h61 + i));
      s0 = n_starts;
      send_msg(m, 0, 1'b0);
      finish_msg();
      chk(n_starts - s0 == tbl[v].starts, "vec_starts", 256'(n_starts - s0), 256'(tbl[v].starts));
      chk(last_core_in[1151:1144] === tbl[v].b0, "vec_byte0", 256'(last_core_in[1151:1144]), 256'(tbl[v].b0));
      chk(last_core_in[71:64] === tbl[v].b135, "vec_byte135", 256'(last_core_in[71:64]), 256'(tbl[v].b135));
      if (tbl[v].len == 3) begin
        chk(last_core_in[1151:1120] === 32'h61626306, "abc_head", 256'(last_core_in[1151:1120]), 256'h61626306);
        chk(last_core_in[1119:72] === '0 && last_core_in[63:0] === 64'd0, "abc_zero", 256'(|last_core_in[1119:72]), 256'd0);
      end
    end

    // Digest held while dig_ready stays low.
    m = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_msg(m, 0, 1'b1);
    wait_dig();
    exp_dig = last_out[511:256];
    for (int i = 0; i < 10; i++) begin
      chk(dig_valid === 1'b1, "hold_dig_valid", 256'(dig_valid), 256'd1);
      chk(dig_data === exp_dig, "hold_dig_data", dig_data, exp_dig);
      chk(in_ready === 1'b0, "hold_in_ready", 256'(in_ready), 256'd0);
      @(negedge clk);
    end
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
    chk(dig_valid === 1'b0, "out_to_idle_valid", 256'(dig_valid), 256'd0);
    chk(in_ready === 1'b1, "out_to_idle_ready", 256'(in_ready), 256'd1);

    // core_done already high on WAIT entry: WAIT must span two cycles.
    stale_mode = 1'b1;
    chk(core_done === 1'b1, "stale_precond", 256'(core_done), 256'd1);
    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, 0, 1'b1);
    @(negedge clk);
    chk(dig_valid === 1'b0, "stale_wait1", 256'(dig_valid), 256'd0);
    @(negedge clk);
    chk(dig_valid === 1'b0, "stale_wait2", 256'(dig_valid), 256'd0);
    @(negedge clk);
    chk(dig_valid === 1'b1, "stale_exit", 256'(dig_valid), 256'd1);
    finish_msg();
    stale_mode = 1'b0;

    // Random messages against the padding model.
    for (int r = 0; r < 25; r++) begin
      int L;
      L = int'($urandom_range(1, 300));
      m = {};
      for (int i = 0; i < L; i++) m.push_back(8'($urandom));
      send_msg(m, 2, 1'b1);
      finish_msg();
    end

    // Reset while the second block of a message sits in WAIT.
    m = {};
    for (int i = 0; i < 200; i++) m.push_back(8'($urandom));
    hold_at = n_starts + 2;
    send_msg(m, 1, 1'b1);
    chk(core_ctrl === CTRL_NEXT, "pre_rst_ctrl", 256'(core_ctrl), 256'(CTRL_NEXT));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("mid_rst");
    reset = 1'b0;
    hold_at = -1;
    exp_q.delete();
    @(negedge clk);
    chk(in_ready === 1'b1, "mid_rst_in_ready", 256'(in_ready), 256'd1);
    m = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_msg(m, 0, 1'b1);
    chk(core_ctrl === CTRL_FIRST, "post_rst_ctrl", 256'(core_ctrl), 256'(CTRL_FIRST));
    finish_msg();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sha3_seq.md
SHA3_SEQ -- requirements
Module: sha3_seq

Interface
REQ-001 Parameter CTRL_FIRST, default 10'b0000010011, core_ctrl value for the first block of a message (SHA3-256, fresh state).
REQ-002 Parameter CTRL_NEXT, default 10'b0000000011, core_ctrl value for every later block of a message (absorb into existing state).
REQ-003 clk  in  1  clock; all logic is on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid / in_ready / in_data  in/out/in  1/1/64  message word stream; the first byte is in_data[63:56].
REQ-006 in_last / in_bytes  in/in  1/3  final word flag and its valid byte count (0 means 8); both are ignored unless in_last=1.
REQ-007 core_start / core_ctrl / core_in  out/out/out  1/10/1152  drive to the sha3 core.
REQ-008 core_done / core_out  in/in  1/512  inputs from the sha3 core.
REQ-009 dig_valid / dig_ready / dig_data  out/in/out  1/1/256  digest output handshake.

Function
REQ-010 States: IDLE, FILL, PAD, START, WAIT, OUT.
REQ-011 A word transfers when in_valid&in_ready; in_ready=1 only in IDLE/FILL.
REQ-012 Word k (0..16) of a block is stored to core_in[1151-64k -: 64]; core_in[63:0] is always 0.
REQ-013 IDLE: the first accepted word moves to FILL, and the block is marked first.
REQ-014 FILL: after word 16 is accepted, or any word with in_last=1, move to PAD.
REQ-015 PAD (1 cycle) applies 0x06 at the first byte after the message, zeroes later bytes, and ORs 0x80 into byte 135 (core_in[71:64]). When both land on byte 135, that byte is 0x86.
REQ-016 A 17-word block without in_last gets no padding. A message ending exactly at word 16 byte 7 triggers one further all-pad block (0x06 at byte 0, 0x80 at byte 135).
REQ-017 START: core_start=1 for exactly one cycle. core_ctrl is CTRL_FIRST for the first block, else CTRL_NEXT, and is held stable until the next START.
REQ-018 WAIT ignores core_done in its first cycle (stale done), then leaves on the first cycle with core_done=1.
REQ-019 From WAIT: if the last block is done, go to OUT; else clear the word counter and go to FILL, or to PAD for a pending all-pad block.
REQ-020 OUT: dig_valid=1 and dig_data=core_out[511:256] is captured at WAIT exit and held stable. dig_valid&dig_ready returns the block to IDLE.
REQ-021 Latency from the last in_valid&in_ready to core_start is 2 cycles (FILL→PAD→START).
REQ-022 A block uses 17 words, 1088 bits, which is the SHA3-256 rate.

Reset
REQ-023 When reset=1, state=IDLE, in_ready=0, core_start=0, core_ctrl=CTRL_FIRST, core_in=0, dig_valid=0, dig_data=0, and all counters are 0; in_ready goes to 1 the cycle after reset deasserts.
REQ-024 Reset mid-message discards all buffered data; the next message starts with CTRL_FIRST.

Configuration
REQ-025 With SHA3_SEQ_PERF_EN defined: output blk_count[15:0] counts core_start pulses since reset, saturates at 16'hFFFF, and is readable at any time. Without the macro the port does not exist.

Verification
REQ-026 Message "abc" (in_data=64'h6162630000000000, in_last=1, in_bytes=3) -> one core_start with core_ctrl=CTRL_FIRST; core_in[1151:1120]=32'h61626306; core_in[71:64]=8'h80; all other bits 0.
REQ-027 16 full words + 1 word with in_bytes=7 -> byte 135 = 8'h86; exactly one core_start.
REQ-028 17 full words, the last with in_last=1 -> two core_starts (CTRL_FIRST then CTRL_NEXT); the second block's core_in[1151:1144]=8'h06 and core_in[71:64]=8'h80.
REQ-029 dig_ready held 0 for 10 cycles in OUT -> dig_valid and dig_data stay stable and in_ready stays 0; dig_ready=1 returns to IDLE the next cycle.
REQ-030 reset pulsed during WAIT -> all outputs return to their reset values; a following single-word message uses CTRL_FIRST.
REQ-031 core_done already high when WAIT is entered -> WAIT lasts at least 2 cycles.
